// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: accepts a PC, optionally waits, reads one word from
// memory and presents it (or a misalignment fault) until the consumer takes it.
module ifetch_responder #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_request,
  input  logic [63:0] pc,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic [63:0] mem_addr,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MEM,
    DATA,
    RESP
  } state_t;

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] addr, addr_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [63:0] inst_pc_q, inst_pc_nxt;
  logic        fault_q, fault_nxt;
  logic        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      inst_q    <= inst_nxt;
      inst_pc_q <= inst_pc_nxt;
      fault_q   <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr;
    inst_nxt    = inst_q;
    inst_pc_nxt = inst_pc_q;
    fault_nxt   = fault_q;
    accept      = 1'b0;

    case (state)
      IDLE: accept = if_request && !flush;
      WAIT: begin
        if (flush)          state_nxt = IDLE;
        else if (cnt == '0) state_nxt = MEM;
        else                cnt_nxt   = cnt - 4'd1;
      end
      MEM:  state_nxt = flush ? IDLE : DATA;
      DATA: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          inst_nxt    = mem_rdata;
          inst_pc_nxt = addr;
          fault_nxt   = 1'b0;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        // flush wins over stall; a consumed response may be replaced in the same edge
        if (flush) begin
          state_nxt = IDLE;
        end else if (!stall) begin
          state_nxt = IDLE;
          accept    = if_request;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (accept) begin
      addr_nxt = pc;
      if (pc[1:0] != 2'b00) begin
        inst_nxt    = '0;
        inst_pc_nxt = pc;
        fault_nxt   = 1'b1;
        state_nxt   = RESP;
      end else if (WAIT_STATES > 0) begin
        cnt_nxt   = WS_INIT;
        state_nxt = WAIT;
      end else begin
        state_nxt = MEM;
      end
    end
  end

  assign mem_en     = (state == MEM);
  assign mem_addr   = addr;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fault      = fault_q;
  assign inst_valid = (state == RESP);
  assign busy       = (state == WAIT) || (state == MEM) || (state == DATA);

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: one instance with no wait states, one with three.
module tb_ifetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_request0 = 1'b0;
  logic        if_request3 = 1'b0;
  logic [63:0] pc = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        mem_en0, inst_valid0, fault0, busy0;
  logic [63:0] mem_addr0, inst_pc0;
  logic [31:0] inst0;
  logic        mem_en3, inst_valid3, fault3, busy3;
  logic [63:0] mem_addr3, inst_pc3;
  logic [31:0] inst3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifetch_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .if_request(if_request0), .pc(pc), .flush(flush),
    .stall(stall), .mem_rdata(mem_rdata), .mem_en(mem_en0), .mem_addr(mem_addr0),
    .inst(inst0), .inst_pc(inst_pc0), .inst_valid(inst_valid0), .fault(fault0),
    .busy(busy0)
  );

  ifetch_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .if_request(if_request3), .pc(pc), .flush(flush),
    .stall(stall), .mem_rdata(mem_rdata), .mem_en(mem_en3), .mem_addr(mem_addr3),
    .inst(inst3), .inst_pc(inst_pc3), .inst_valid(inst_valid3), .fault(fault3),
    .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // asynchronous reset with no clock edge involved
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 64'(inst_valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_mem_en", 64'(mem_en0), 64'd0);
    chk("rst_mem_addr", mem_addr0, 64'd0);
    chk("rst_inst", 64'(inst0), 64'd0);
    chk("rst_inst_pc", inst_pc0, 64'd0);
    chk("rst_fault", 64'(fault0), 64'd0);
    step();
    step();
    rst = 1'b0;

    // aligned fetch, no wait states; first accept right after reset release
    chk("a0_idle_mem_en", 64'(mem_en0), 64'd0);
    if_request0 = 1'b1; pc = 64'h100;
    step();
    chk("a0_t1_mem_en", 64'(mem_en0), 64'd1);
    chk("a0_t1_mem_addr", mem_addr0, 64'h100);
    chk("a0_t1_busy", 64'(busy0), 64'd1);
    chk("a0_t1_valid", 64'(inst_valid0), 64'd0);
    if_request0 = 1'b0; mem_rdata = 32'h00500093;
    step();
    chk("a0_t2_mem_en", 64'(mem_en0), 64'd0);
    chk("a0_t2_valid", 64'(inst_valid0), 64'd0);
    step();
    chk("a0_t3_valid", 64'(inst_valid0), 64'd1);
    chk("a0_t3_inst", 64'(inst0), 64'h00500093);
    chk("a0_t3_inst_pc", inst_pc0, 64'h100);
    chk("a0_t3_fault", 64'(fault0), 64'd0);
    chk("a0_t3_busy", 64'(busy0), 64'd0);
    step();
    chk("a0_t4_valid", 64'(inst_valid0), 64'd0);

    // three wait states; requests while busy are ignored
    if_request3 = 1'b1; pc = 64'h8;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("w3_t%0d_busy", k), 64'(busy3), 64'd1);
      chk($sformatf("w3_t%0d_mem_en", k), 64'(mem_en3), (k == 4) ? 64'd1 : 64'd0);
      chk($sformatf("w3_t%0d_valid", k), 64'(inst_valid3), 64'd0);
      if (k == 4) begin
        chk("w3_mem_addr", mem_addr3, 64'h8);
        mem_rdata = 32'h12345678;
      end
      if_request3 = ((k % 2) == 1) && (k < 5);
      pc = 64'h40;
      if (k == 5) stall = 1'b1;
    end
    step();
    chk("w3_t6_valid", 64'(inst_valid3), 64'd1);
    chk("w3_t6_inst", 64'(inst3), 64'h12345678);
    chk("w3_t6_inst_pc", inst_pc3, 64'h8);
    chk("w3_t6_busy", 64'(busy3), 64'd0);

    // held response under stall, then back-to-back accept
    for (int k = 0; k < 4; k++) begin
      mem_rdata = ~mem_rdata;
      step();
      chk($sformatf("st%0d_valid", k), 64'(inst_valid3), 64'd1);
      chk($sformatf("st%0d_inst", k), 64'(inst3), 64'h12345678);
      chk($sformatf("st%0d_inst_pc", k), inst_pc3, 64'h8);
    end
    stall = 1'b0; if_request3 = 1'b1; pc = 64'h104;
    step();
    chk("b2b_t1_valid", 64'(inst_valid3), 64'd0);
    chk("b2b_t1_busy", 64'(busy3), 64'd1);
    if_request3 = 1'b0; mem_rdata = 32'hCAFEF00D;
    for (int k = 2; k <= 6; k++) step();
    chk("b2b_t6_valid", 64'(inst_valid3), 64'd1);
    chk("b2b_t6_inst_pc", inst_pc3, 64'h104);
    chk("b2b_t6_inst", 64'(inst3), 64'hCAFEF00D);
    step();
    chk("b2b_t7_valid", 64'(inst_valid3), 64'd0);

    // misaligned fetch
    if_request0 = 1'b1; pc = 64'h102;
    step();
    chk("mis_valid", 64'(inst_valid0), 64'd1);
    chk("mis_fault", 64'(fault0), 64'd1);
    chk("mis_inst", 64'(inst0), 64'd0);
    chk("mis_inst_pc", inst_pc0, 64'h102);
    chk("mis_mem_en", 64'(mem_en0), 64'd0);
    chk("mis_busy", 64'(busy0), 64'd0);
    if_request0 = 1'b0;
    step();
    chk("mis_t2_valid", 64'(inst_valid0), 64'd0);
    chk("mis_t2_mem_en", 64'(mem_en0), 64'd0);

    // flush during MEM
    if_request0 = 1'b1; pc = 64'h200;
    step();
    chk("fm_mem_en", 64'(mem_en0), 64'd1);
    if_request0 = 1'b0; flush = 1'b1;
    step();
    chk("fm_t2_busy", 64'(busy0), 64'd0);
    chk("fm_t2_valid", 64'(inst_valid0), 64'd0);
    flush = 1'b0;
    step();
    chk("fm_t3_valid", 64'(inst_valid0), 64'd0);
    step();
    chk("fm_t4_valid", 64'(inst_valid0), 64'd0);

    // flush in RESP under stall, with a competing request
    if_request0 = 1'b1; pc = 64'h300; mem_rdata = 32'h11111111;
    step();
    if_request0 = 1'b0;
    step();
    step();
    chk("fr_valid", 64'(inst_valid0), 64'd1);
    chk("fr_inst_pc", inst_pc0, 64'h300);
    stall = 1'b1; flush = 1'b1; if_request0 = 1'b1; pc = 64'h304;
    step();
    chk("fr_t1_valid", 64'(inst_valid0), 64'd0);
    chk("fr_t1_busy", 64'(busy0), 64'd0);
    chk("fr_t1_mem_en", 64'(mem_en0), 64'd0);
    stall = 1'b0; if_request0 = 1'b0;
    // flush still high in IDLE with a request: must not accept
    if_request0 = 1'b1; pc = 64'h400;
    step();
    chk("fi_busy", 64'(busy0), 64'd0);
    chk("fi_mem_en", 64'(mem_en0), 64'd0);
    chk("fi_valid", 64'(inst_valid0), 64'd0);
    flush = 1'b0; if_request0 = 1'b0;

    // asynchronous reset while in WAIT
    if_request3 = 1'b1; pc = 64'h500;
    step();
    chk("rw_busy", 64'(busy3), 64'd1);
    if_request3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rw_busy_rst", 64'(busy3), 64'd0);
    chk("rw_mem_addr_rst", mem_addr3, 64'd0);
    chk("rw_inst_rst", 64'(inst3), 64'd0);
    chk("rw_inst_pc_rst", inst_pc3, 64'd0);
    chk("rw_valid_rst", 64'(inst_valid3), 64'd0);
    chk("rw_fault_rst", 64'(fault3), 64'd0);
    chk("rw_mem_en_rst", 64'(mem_en3), 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rw_post%0d_valid", k), 64'(inst_valid3), 64'd0);
      chk($sformatf("rw_post%0d_mem_en", k), 64'(mem_en3), 64'd0);
    end
    if_request3 = 1'b1; pc = 64'h600; mem_rdata = 32'h0BADC0DE;
    step();
    if_request3 = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    chk("rw_new_valid", 64'(inst_valid3), 64'd1);
    chk("rw_new_inst_pc", inst_pc3, 64'h600);
    chk("rw_new_inst", 64'(inst3), 64'h0BADC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
